// File: rtl/client_ni_if.sv
// Client/router message bus for client_ni.
//   c_i    client injection message      c_full  injection FIFO full
//   c_o    ejected message to client     r_free  router injection slot empty
//   r_i    message into router           r_o     message out of router
// Message layout: {v, d, addr[A_W-1:0], data[D_W-1:0]}.
interface client_ni_if #(
  parameter int unsigned N   = 2,
  parameter int unsigned D_W = 32,
  parameter int unsigned A_W = $clog2(N) + 1
);
  localparam int unsigned MSG_W = A_W + D_W + 2;

  logic [MSG_W-1:0] c_i;
  logic             c_full;
  logic [MSG_W-1:0] c_o;
  logic             r_free;
  logic [MSG_W-1:0] r_i;
  logic [MSG_W-1:0] r_o;

  // Client/router side (drives injections and router outputs)
  modport master (output c_i, input c_full, input c_o,
                  output r_free, input r_i, output r_o);
  // Network interface side
  modport slave  (input c_i, output c_full, output c_o,
                  input r_free, output r_i, input r_o);
endinterface

// File: rtl/client_ni.sv
// Router-side network interface for one deflection-BFT leaf.
// Queues client injections, issues them into the router when its slot is free,
// re-injects bounced packets ahead of new traffic and ejects packets for this leaf.
//   clk, rst (async active-low), ce (clock enable, all registers hold when 0)
//   bus    : client_ni_if.slave (c_i, c_full, c_o, r_free, r_i, r_o)
//   sent   : packets issued on r_i     recv : packets ejected on c_o
//   drops  : client messages lost      done : everything drained
module client_ni #(
  parameter int unsigned N     = 2,
  parameter int unsigned D_W   = 32,
  parameter int unsigned A_W   = $clog2(N) + 1,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned posx  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  client_ni_if.slave  bus,
  output logic [15:0] sent,
  output logic [15:0] recv,
  output logic [15:0] drops,
  output logic        done
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam int unsigned ENT_W = A_W + D_W;
  localparam int unsigned CNT_W = 16;

  typedef struct packed {
    logic           v;
    logic           d;
    logic [A_W-1:0] addr;
    logic [D_W-1:0] data;
  } msg_t;

  typedef enum logic [1:0] {SEL_IDLE, SEL_REINJ, SEL_QUEUE} sel_t;

  msg_t             w_ci, w_ro;
  logic             w_unused_c;

  logic [ENT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic             r_slot_v;
  logic [ENT_W-1:0] r_slot_ent;
  msg_t             r_ri, r_co;
  logic [CNT_W-1:0] r_sent, r_recv, r_drops;
  logic             r_done;

  sel_t             w_sel;
  logic             w_empty, w_full;
  logic             w_issue, w_pop, w_push, w_drop;
  logic             w_eject, w_bounce, w_slot_free, w_capture;
  logic [ENT_W-1:0] w_issue_ent;
  logic [PTR_W-1:0] w_wr_nxt, w_rd_nxt;
  logic             w_slot_v_nxt;
  msg_t             w_ri_nxt, w_co_nxt;
  logic             w_done_nxt;

  assign w_ci = bus.c_i;
  assign w_ro = bus.r_o;
  // Client d bit carries no meaning on injection
  assign w_unused_c = w_ci.d;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]) &&
                   (r_wr_ptr[PTR_W-1] != r_rd_ptr[PTR_W-1]);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    return (en && (c != '1)) ? c + CNT_W'(1) : c;
  endfunction

  // Issue arbitration, classification of router output and next-state values
  always_comb begin
    w_sel = SEL_IDLE;
    if (r_slot_v)      w_sel = SEL_REINJ;
    else if (!w_empty) w_sel = SEL_QUEUE;

    w_issue     = bus.r_free && (w_sel != SEL_IDLE);
    w_pop       = bus.r_free && (w_sel == SEL_QUEUE);
    // A full FIFO still accepts when the head leaves in the same cycle
    w_push      = w_ci.v && (!w_full || w_pop);
    w_drop      = w_ci.v && !w_push;
    w_issue_ent = (w_sel == SEL_REINJ) ? r_slot_ent : r_mem[r_rd_ptr[IDX_W-1:0]];

    w_eject     = w_ro.v && (w_ro.addr == A_W'(posx));
    w_bounce    = w_ro.v && w_ro.d && (w_ro.addr != A_W'(posx));
    // Slot may be refilled in the cycle it is being issued
    w_slot_free = !r_slot_v || (w_issue && (w_sel == SEL_REINJ));
    w_capture   = w_bounce && w_slot_free;

    w_slot_v_nxt = r_slot_v;
    if (w_issue && (w_sel == SEL_REINJ)) w_slot_v_nxt = 1'b0;
    if (w_capture)                       w_slot_v_nxt = 1'b1;

    w_wr_nxt = r_wr_ptr + PTR_W'(w_push);
    w_rd_nxt = r_rd_ptr + PTR_W'(w_pop);

    w_ri_nxt = '0;
    if (w_issue) w_ri_nxt = {1'b1, 1'b0, w_issue_ent};

    w_co_nxt = '0;
    if (w_eject) w_co_nxt = {1'b1, 1'b0, w_ro.addr, w_ro.data};

    w_done_nxt = (w_wr_nxt == w_rd_nxt) && !w_slot_v_nxt && !w_issue && !w_eject;
  end

  // Control state, output registers and counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_slot_v   <= 1'b0;
      r_slot_ent <= '0;
      r_ri       <= '0;
      r_co       <= '0;
      r_sent     <= '0;
      r_recv     <= '0;
      r_drops    <= '0;
      r_done     <= 1'b1;
    end else if (ce) begin
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_slot_v <= w_slot_v_nxt;
      if (w_capture) r_slot_ent <= {w_ro.addr, w_ro.data};
      r_ri     <= w_ri_nxt;
      r_co     <= w_co_nxt;
      r_sent   <= sat_inc(r_sent, w_issue);
      r_recv   <= sat_inc(r_recv, w_eject);
      r_drops  <= sat_inc(r_drops, w_drop);
      r_done   <= w_done_nxt;
    end
  end

  // FIFO storage needs no reset; validity lives in the pointers
  always_ff @(posedge clk) begin
    if (ce && w_push) r_mem[r_wr_ptr[IDX_W-1:0]] <= {w_ci.addr, w_ci.data};
  end

  // A bounce arriving while the slot stays occupied is lost; the older entry is kept
  a_bounce_overrun: assert property (@(posedge clk) disable iff (!rst)
    !(ce && w_bounce && !w_slot_free))
    else $error("client_ni: bounce while reinject slot occupied, new packet discarded");

  assign bus.c_full = w_full;
  assign bus.c_o    = r_co;
  assign bus.r_i    = r_ri;
  assign sent       = r_sent;
  assign recv       = r_recv;
  assign drops      = r_drops;
  assign done       = r_done;
endmodule

// File: tb/tb_client_ni.sv
// Testbench for client_ni: vector table, directed multi-cycle sequences and
// randomized traffic checked against a queue-based reference model.
module tb_client_ni;
  localparam int unsigned N     = 2;
  localparam int unsigned D_W   = 32;
  localparam int unsigned A_W   = $clog2(N) + 1;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned POSX  = 0;
  localparam int unsigned MSG_W = A_W + D_W + 2;
  localparam int unsigned ENT_W = A_W + D_W;

  typedef logic [MSG_W-1:0] msg_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [15:0] sent, recv, drops;
  logic        done;

  client_ni_if #(.N(N), .D_W(D_W), .A_W(A_W)) bus ();

  client_ni #(.N(N), .D_W(D_W), .A_W(A_W), .DEPTH(DEPTH), .posx(POSX)) dut (
    .clk(clk), .rst(rst), .ce(ce), .bus(bus),
    .sent(sent), .recv(recv), .drops(drops), .done(done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [ENT_W-1:0] mq[$];
  logic             m_slot_v;
  logic [ENT_W-1:0] m_slot;
  msg_t             m_ri, m_co;
  int               m_sent, m_recv, m_drops;
  logic             m_done;

  function automatic msg_t mk(input logic v, input logic d, input logic [A_W-1:0] a,
                              input logic [D_W-1:0] dat);
    return {v, d, a, dat};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_slot_v = 1'b0; m_slot = '0;
    m_ri = '0; m_co = '0;
    m_sent = 0; m_recv = 0; m_drops = 0;
    m_done = 1'b1;
  endtask

  function automatic int sat(input int c);
    return (c < 65535) ? c + 1 : c;
  endfunction

  // One clock edge of the interface as described in words: issue, then accept, then router output
  task automatic model_edge();
    msg_t             ci, ro;
    logic             issued;
    logic [ENT_W-1:0] iss;
    ci = bus.c_i;
    ro = bus.r_o;
    if (!ce) return;
    issued = 1'b0;
    iss    = '0;
    if (bus.r_free && m_slot_v) begin
      issued = 1'b1; iss = m_slot; m_slot_v = 1'b0;
    end else if (bus.r_free && mq.size() > 0) begin
      issued = 1'b1; iss = mq.pop_front();
    end
    if (ci[MSG_W-1]) begin
      if (mq.size() < int'(DEPTH)) mq.push_back(ci[ENT_W-1:0]);
      else m_drops = sat(m_drops);
    end
    m_co = '0;
    if (ro[MSG_W-1] && ro[ENT_W-1:D_W] == A_W'(POSX)) begin
      m_co   = mk(1'b1, 1'b0, ro[ENT_W-1:D_W], ro[D_W-1:0]);
      m_recv = sat(m_recv);
    end else if (ro[MSG_W-1] && ro[MSG_W-2] && !m_slot_v) begin
      m_slot_v = 1'b1; m_slot = ro[ENT_W-1:0];
    end
    m_ri = '0;
    if (issued) begin
      m_ri   = {1'b1, 1'b0, iss};
      m_sent = sat(m_sent);
    end
    m_done = (mq.size() == 0) && !m_slot_v && !m_ri[MSG_W-1] && !m_co[MSG_W-1];
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_r_i"},    64'(bus.r_i),    64'(m_ri));
    chk({tag, "_c_o"},    64'(bus.c_o),    64'(m_co));
    chk({tag, "_c_full"}, 64'(bus.c_full), 64'(mq.size() == int'(DEPTH)));
    chk({tag, "_sent"},   64'(sent),       64'(m_sent));
    chk({tag, "_recv"},   64'(recv),       64'(m_recv));
    chk({tag, "_drops"},  64'(drops),      64'(m_drops));
    chk({tag, "_done"},   64'(done),       64'(m_done));
  endtask

  task automatic drive(input logic e, input logic civ, input logic cdd, input logic [A_W-1:0] ca,
                       input logic [D_W-1:0] cd, input logic rf, input logic rov, input logic rod,
                       input logic [A_W-1:0] ra, input logic [D_W-1:0] rd);
    ce         = e;
    bus.c_i    = mk(civ, cdd, ca, cd);
    bus.r_free = rf;
    bus.r_o    = mk(rov, rod, ra, rd);
  endtask

  task automatic idle(input logic rf);
    drive(1'b1, 1'b0, 1'b0, '0, '0, rf, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (rst) model_edge();
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset();
    idle(1'b0);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    compare_all("rst");
    @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    logic           ce;
    logic           civ;
    logic [A_W-1:0] ca;
    logic [D_W-1:0] cd;
    logic           rf;
    logic           rov;
    logic           rod;
    logic [A_W-1:0] ra;
    logic [D_W-1:0] rd;
    msg_t           e_ri;
    msg_t           e_co;
    int             e_sent;
    int             e_recv;
    int             e_drops;
    logic           e_done;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ce civ ca cd rf rov rod ra rd | r_i c_o sent recv drops done
    tbl[0]  = '{1, 1, 1, 32'h11,   1, 0, 0, 0, 32'h0,    '0, '0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 32'h0,    1, 0, 0, 0, 32'h0,    mk(1, 0, 1, 32'h11), '0, 1, 0, 0, 0};
    tbl[2]  = '{1, 0, 0, 32'h0,    1, 1, 0, 0, 32'h1234, '0, mk(1, 0, 0, 32'h1234), 1, 1, 0, 0};
    tbl[3]  = '{1, 0, 0, 32'h0,    1, 1, 0, 2, 32'h55,   '0, '0, 1, 1, 0, 1};
    tbl[4]  = '{1, 1, 2, 32'h22,   0, 0, 0, 0, 32'h0,    '0, '0, 1, 1, 0, 0};
    tbl[5]  = '{1, 0, 0, 32'h0,    0, 1, 1, 3, 32'h33,   '0, '0, 1, 1, 0, 0};
    tbl[6]  = '{1, 0, 0, 32'h0,    1, 0, 0, 0, 32'h0,    mk(1, 0, 3, 32'h33), '0, 2, 1, 0, 0};
    tbl[7]  = '{1, 0, 0, 32'h0,    1, 0, 0, 0, 32'h0,    mk(1, 0, 2, 32'h22), '0, 3, 1, 0, 0};
    tbl[8]  = '{1, 0, 0, 32'h0,    1, 0, 0, 0, 32'h0,    '0, '0, 3, 1, 0, 1};
    tbl[9]  = '{1, 0, 0, 32'h0,    1, 1, 1, 0, 32'hABCD, '0, mk(1, 0, 0, 32'hABCD), 3, 2, 0, 0};
    tbl[10] = '{0, 1, 1, 32'h99,   1, 1, 0, 0, 32'h77,   '0, mk(1, 0, 0, 32'hABCD), 3, 2, 0, 0};
    tbl[11] = '{1, 0, 0, 32'h0,    1, 0, 0, 0, 32'h0,    '0, '0, 3, 2, 0, 1};

    // Reset held with traffic present
    rst = 1'b0;
    model_reset();
    drive(1'b1, 1'b1, 1'b0, 1, 32'h5, 1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      compare_all("hold_rst");
    end
    chk("hold_rst_done", 64'(done), 64'd1);
    @(negedge clk);
    rst = 1'b1;

    // Vector table
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].ce, tbl[i].civ, 1'b1, tbl[i].ca, tbl[i].cd, tbl[i].rf,
            tbl[i].rov, tbl[i].rod, tbl[i].ra, tbl[i].rd);
      step($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_ri", i),    64'(bus.r_i), 64'(tbl[i].e_ri));
      chk($sformatf("tbl%0d_co", i),    64'(bus.c_o), 64'(tbl[i].e_co));
      chk($sformatf("tbl%0d_sent", i),  64'(sent),    64'(tbl[i].e_sent));
      chk($sformatf("tbl%0d_recv", i),  64'(recv),    64'(tbl[i].e_recv));
      chk($sformatf("tbl%0d_drops", i), 64'(drops),   64'(tbl[i].e_drops));
      chk($sformatf("tbl%0d_done", i),  64'(done),    64'(tbl[i].e_done));
    end

    // Overfill with the router blocked, then drain in order
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1, D_W'(i), 1'b0, 1'b0, 1'b0, '0, '0);
      step("fill");
      if (i == 2) chk("fill3_c_full", 64'(bus.c_full), 64'd0);
      if (i == 3) chk("fill4_c_full", 64'(bus.c_full), 64'd1);
    end
    chk("fill_drops", 64'(drops), 64'd2);
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      step("drain");
      chk($sformatf("drain%0d_ri", i), 64'(bus.r_i), 64'(mk(1, 0, 1, D_W'(i))));
    end
    idle(1'b1);
    step("drain_end");
    chk("drain_sent", 64'(sent), 64'd4);
    chk("drain_done", 64'(done), 64'd1);

    // Full FIFO with simultaneous push and pop, wrapping the pointers
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1, D_W'(100 + i), 1'b0, 1'b0, 1'b0, '0, '0);
      step("wfill");
    end
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 1'b1, 1'b0, 1, D_W'(104 + k), 1'b1, 1'b0, 1'b0, '0, '0);
      step("wrap");
      chk($sformatf("wrap%0d_ri", k),   64'(bus.r_i),    64'(mk(1, 0, 1, D_W'(100 + k))));
      chk($sformatf("wrap%0d_full", k), 64'(bus.c_full), 64'd1);
    end
    chk("wrap_drops", 64'(drops), 64'd0);
    for (int k = 0; k < 4; k++) begin
      idle(1'b1);
      step("wdrain");
      chk($sformatf("wdrain%0d_ri", k), 64'(bus.r_i), 64'(mk(1, 0, 1, D_W'(110 + k))));
    end
    idle(1'b1);
    step("wdrain_end");
    chk("wdrain_done", 64'(done), 64'd1);

    // Asynchronous reset mid-operation
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, 2, D_W'(200 + i), 1'b0, 1'b0, 1'b0, '0, '0);
      step("afill");
    end
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 0, 32'hBEEF);
    step("abusy");
    chk("abusy_ri", 64'(bus.r_i), 64'(mk(1, 0, 2, D_W'(200))));
    chk("abusy_co", 64'(bus.c_o), 64'(mk(1, 0, 0, 32'hBEEF)));
    idle(1'b1);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("arst_ri",     64'(bus.r_i),    64'd0);
    chk("arst_co",     64'(bus.c_o),    64'd0);
    chk("arst_done",   64'(done),       64'd1);
    chk("arst_c_full", 64'(bus.c_full), 64'd0);
    chk("arst_sent",   64'(sent),       64'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      step("apost");
      chk($sformatf("apost%0d_riv", i), 64'(bus.r_i[MSG_W-1]), 64'd0);
    end

    // Randomized traffic against the reference model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      logic           e, civ, rf, rov, rod;
      logic [A_W-1:0] ca, ra;
      int             kind;
      e    = ($urandom_range(0, 9) != 0);
      civ  = ($urandom_range(0, 9) < 6);
      rf   = ($urandom_range(0, 1) == 1);
      ca   = A_W'($urandom_range(0, 3));
      kind = int'($urandom_range(0, 3));
      rov  = 1'b0; rod = 1'b0; ra = '0;
      if (kind == 1) begin
        rov = 1'b1; rod = 1'(($urandom_range(0, 1))); ra = A_W'(POSX);
      end else if (kind == 2) begin
        rov = 1'b1; rod = 1'b0; ra = A_W'($urandom_range(1, 3));
      end else if (kind == 3 && (!m_slot_v || rf)) begin
        rov = 1'b1; rod = 1'b1; ra = A_W'($urandom_range(1, 3));
      end
      drive(e, civ, 1'(($urandom_range(0, 1))), ca, D_W'($urandom), rf, rov, rod, ra,
            D_W'($urandom));
      step("rnd");
    end
    idle(1'b1);
    for (int i = 0; i < 8; i++) step("rnd_drain");
    chk("rnd_done", 64'(done), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
